// File: rtl/dff_pipe.sv
// WIDTH-bit, STAGES-deep handshaked register pipeline. Empty stages keep filling
// under backpressure, so bubbles compress; flush and async reset clear every stage.
module dff_pipe #(
    parameter int              WIDTH     = 8,
    parameter int              STAGES    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] up_v;
    logic [WIDTH-1:0]  d    [STAGES];
    logic [WIDTH-1:0]  up_d [STAGES];

    // A stage can load when it is empty or everything downstream of it moves.
    // A scalar accumulator keeps the chain free of vector self-dependency.
    always_comb begin
        logic acc;
        acc = out_ready;
        rdy = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc    = acc | ~v[i];
            rdy[i] = acc;
        end
    end

    assign in_ready = rdy[0] & ~flush;

    always_comb begin
        up_v    = '0;
        up_v[0] = in_valid & in_ready;
        up_d[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = d[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) d[i] <= RESET_VAL;
        end else if (flush) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++) d[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v[i] <= up_v[i];
                    if (up_v[i]) d[i] <= up_d[i];
                end
            end
        end
    end

    always_comb begin
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < STAGES; i++) cnt = cnt + OCC_W'(v[i]);
        occupancy = cnt;
    end

    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: a 4-stage instance and a 1-stage instance (RESET_VAL 0xFF),
// each with a scoreboard queue filled on accept and drained on delivery.
module tb_dff_pipe;

    logic       clk;
    logic       rst_n;
    logic       flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [2:0] occupancy;

    logic       flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [7:0] in_data_b, out_data_b;
    logic [0:0] occupancy_b;

    int assertions = 0;
    int failures   = 0;
    int delivered_a = 0;
    logic [7:0] sb_a [$];
    logic [7:0] sb_b [$];
    logic [7:0] exp_a, exp_b;

    dff_pipe #(.WIDTH(8), .STAGES(4), .RESET_VAL(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    dff_pipe #(.WIDTH(8), .STAGES(1), .RESET_VAL(8'hFF)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .occupancy(occupancy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboards sample 1 time unit before each posedge.
    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            sb_a.delete();
        end else begin
            if (out_valid && out_ready) begin
                assertions++;
                delivered_a++;
                if (sb_a.size() == 0) begin
                    failures++;
                    $display("FAIL sb_a_unexpected: got beat %h, expected none", out_data);
                end else begin
                    exp_a = sb_a.pop_front();
                    if (out_data !== exp_a) begin
                        failures++;
                        $display("FAIL sb_a_data: got %h, expected %h", out_data, exp_a);
                    end
                end
            end
            if (flush) sb_a.delete();
            if (in_valid && in_ready) sb_a.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            sb_b.delete();
        end else begin
            if (out_valid_b && out_ready_b) begin
                assertions++;
                if (sb_b.size() == 0) begin
                    failures++;
                    $display("FAIL sb_b_unexpected: got beat %h, expected none", out_data_b);
                end else begin
                    exp_b = sb_b.pop_front();
                    if (out_data_b !== exp_b) begin
                        failures++;
                        $display("FAIL sb_b_data: got %h, expected %h", out_data_b, exp_b);
                    end
                end
            end
            if (flush_b) sb_b.delete();
            if (in_valid_b && in_ready_b) sb_b.push_back(in_data_b);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        assertions++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        assertions++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h, expected 00", out_data); end
        assertions++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy: got %0d, expected 0", occupancy); end
        assertions++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        assertions++; if (out_data_b !== 8'hFF) begin failures++; $display("FAIL reset_s1_out_data: got %h, expected ff", out_data_b); end
        assertions++; if (out_valid_b !== 1'b0) begin failures++; $display("FAIL reset_s1_out_valid: got %b, expected 0", out_valid_b); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'(k);
            #1;
            assertions++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready: beat %0d got %b, expected 1", k, in_ready); end
            if (k == 4) begin
                assertions++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_latency_early: got out_valid %b, expected 0", out_valid); end
            end
            if (k == 5) begin
                assertions++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin failures++; $display("FAIL stream_latency: got %b/%h, expected 1/01", out_valid, out_data); end
            end
            if (k == 8) begin
                assertions++; if (occupancy !== 3'd4) begin failures++; $display("FAIL stream_occupancy: got %0d, expected 4", occupancy); end
            end
        end
        idle(6);
        #1;
        assertions++; if (delivered_a !== 16) begin failures++; $display("FAIL stream_count: got %0d beats, expected 16", delivered_a); end
        assertions++; if (sb_a.size() !== 0 || occupancy !== 3'd0) begin failures++; $display("FAIL stream_drain: got %0d pending occ %0d, expected 0/0", sb_a.size(), occupancy); end
    endtask

    task automatic test_bubble;
        out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = 8'hA1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = 8'hA2;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); #1;
        assertions++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin failures++; $display("FAIL bubble_head: got %b/%h, expected 1/a1", out_valid, out_data); end
        @(negedge clk); #1;
        assertions++; if (occupancy !== 3'd2 || in_ready !== 1'b1) begin failures++; $display("FAIL bubble_packed: got occ %0d rdy %b, expected 2/1", occupancy, in_ready); end
        @(negedge clk); in_valid = 1'b1; in_data = 8'hA3; #1;
        assertions++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_accept_a3: got %b, expected 1", in_ready); end
        @(negedge clk); in_data = 8'hA4; #1;
        assertions++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_accept_a4: got %b, expected 1", in_ready); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); in_data = 8'h55; #1;
            assertions++; if (in_ready !== 1'b0 || occupancy !== 3'd4) begin failures++; $display("FAIL bubble_full: got rdy %b occ %0d, expected 0/4", in_ready, occupancy); end
            assertions++; if (out_data !== 8'hA1) begin failures++; $display("FAIL bubble_stable: got %h, expected a1", out_data); end
        end
        @(negedge clk); out_ready = 1'b1; #1;
        assertions++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_release: got %b, expected 1", in_ready); end
        idle(6);
        #1;
        assertions++; if (sb_a.size() !== 0 || occupancy !== 3'd0) begin failures++; $display("FAIL bubble_drain: got %0d pending occ %0d, expected 0/0", sb_a.size(), occupancy); end
    endtask

    task automatic test_full_passthrough;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 8'hB0 + 8'(k);
        end
        @(negedge clk); in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1; #1;
        assertions++; if (in_ready !== 1'b1 || occupancy !== 3'd4) begin failures++; $display("FAIL full_pass_ready: got rdy %b occ %0d, expected 1/4", in_ready, occupancy); end
        @(negedge clk); in_valid = 1'b0; #1;
        assertions++; if (occupancy !== 3'd4 || out_data !== 8'hB1) begin failures++; $display("FAIL full_pass_shift: got occ %0d data %h, expected 4/b1", occupancy, out_data); end
        idle(6);
        #1;
        assertions++; if (sb_a.size() !== 0 || occupancy !== 3'd0) begin failures++; $display("FAIL full_pass_drain: got %0d pending occ %0d, expected 0/0", sb_a.size(), occupancy); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 8'hC1 + 8'(k);
        end
        @(negedge clk); flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; #1;
        assertions++; if (in_ready !== 1'b0 || occupancy !== 3'd3) begin failures++; $display("FAIL flush_cycle: got rdy %b occ %0d, expected 0/3", in_ready, occupancy); end
        @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
        assertions++; if (occupancy !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin failures++; $display("FAIL flush_after: got occ %0d v %b d %h, expected 0/0/00", occupancy, out_valid, out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            assertions++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost: got out_valid %b data %h, expected 0", out_valid, out_data); end
        end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 8'hD1 + 8'(k);
        end
        @(negedge clk); in_valid = 1'b0; #1;
        assertions++; if (occupancy !== 3'd4) begin failures++; $display("FAIL areset_prefill: got occ %0d, expected 4", occupancy); end
        #1 rst_n = 1'b0;
        #1;
        assertions++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin failures++; $display("FAIL areset_immediate: got %b/%h, expected 0/00", out_valid, out_data); end
        assertions++; if (occupancy !== 3'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL areset_state: got occ %0d rdy %b, expected 0/1", occupancy, in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            if (c < 4) begin
                assertions++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_resume_early: cycle %0d got %b, expected 0", c, out_valid); end
            end else begin
                assertions++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin failures++; $display("FAIL areset_resume: got %b/%h, expected 1/3c", out_valid, out_data); end
            end
        end
        idle(2);
    endtask

    task automatic test_stages1;
        out_ready_b = 1'b1;
        @(negedge clk); in_valid_b = 1'b1; in_data_b = 8'h12; #1;
        assertions++; if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0) begin failures++; $display("FAIL s1_first: got rdy %b v %b, expected 1/0", in_ready_b, out_valid_b); end
        @(negedge clk); in_data_b = 8'h34; #1;
        assertions++; if (out_valid_b !== 1'b1 || out_data_b !== 8'h12) begin failures++; $display("FAIL s1_out12: got %b/%h, expected 1/12", out_valid_b, out_data_b); end
        assertions++; if (in_ready_b !== 1'b1) begin failures++; $display("FAIL s1_back_to_back: got %b, expected 1", in_ready_b); end
        @(negedge clk); in_valid_b = 1'b0; #1;
        assertions++; if (out_valid_b !== 1'b1 || out_data_b !== 8'h34) begin failures++; $display("FAIL s1_out34: got %b/%h, expected 1/34", out_valid_b, out_data_b); end
        @(negedge clk); out_ready_b = 1'b0; in_valid_b = 1'b1; in_data_b = 8'h56; #1;
        assertions++; if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin failures++; $display("FAIL s1_empty: got v %b rdy %b, expected 0/1", out_valid_b, in_ready_b); end
        @(negedge clk); in_data_b = 8'h78; #1;
        assertions++; if (in_ready_b !== 1'b0 || occupancy_b !== 1'b1 || out_data_b !== 8'h56) begin failures++; $display("FAIL s1_stall: got rdy %b occ %0d d %h, expected 0/1/56", in_ready_b, occupancy_b, out_data_b); end
        @(negedge clk); out_ready_b = 1'b1; #1;
        assertions++; if (in_ready_b !== 1'b1) begin failures++; $display("FAIL s1_release: got %b, expected 1", in_ready_b); end
        @(negedge clk); in_valid_b = 1'b0; #1;
        assertions++; if (out_data_b !== 8'h78) begin failures++; $display("FAIL s1_out78: got %h, expected 78", out_data_b); end
        @(negedge clk); #1;
        assertions++; if (sb_b.size() !== 0 || occupancy_b !== 1'b0) begin failures++; $display("FAIL s1_drain: got %0d pending occ %0d, expected 0/0", sb_b.size(), occupancy_b); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_bubble();
        test_full_passthrough();
        test_flush();
        test_async_reset();
        test_stages1();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
